// File: rtl/mode_sequencer_pkg.sv
// mode_sequencer_pkg: state encoding and registered output bundle shared by the sequencer and its users
package mode_sequencer_pkg;
  localparam int MODE_W = 3;
  typedef enum logic [MODE_W-1:0] {
    S_IDLE = 3'd0,
    S_RX   = 3'd1,
    S_PROC = 3'd2,
    S_TX   = 3'd3,
    S_ERR  = 3'd4
  } state_t;
  typedef struct packed {
    logic              rx_start;
    logic              proc_start;
    logic              tx_start;
    logic              rx_en;
    logic              proc_en;
    logic              tx_en;
    logic              abort;
    logic              cmd_reject;
    logic [MODE_W-1:0] mode;
    logic              busy;
    logic              img_loaded;
    logic              img_processed;
    logic              timeout_err;
  } out_t;
  function automatic logic is_busy(state_t s);
    return s == S_RX || s == S_PROC || s == S_TX;
  endfunction
endpackage

// File: rtl/mode_sequencer_if.sv
// mode_sequencer_if: command/done inputs and control/status outputs of the sequencer
interface mode_sequencer_if;
  import mode_sequencer_pkg::*;
  logic              cmd_pc_ram;
  logic              cmd_ram_pc;
  logic              cmd_process;
  logic              cmd_idle;
  logic              rx_done;
  logic              proc_done;
  logic              tx_done;
  logic              rx_start;
  logic              proc_start;
  logic              tx_start;
  logic              rx_en;
  logic              proc_en;
  logic              tx_en;
  logic              abort;
  logic              cmd_reject;
  logic [MODE_W-1:0] mode;
  logic              busy;
  logic              img_loaded;
  logic              img_processed;
  logic              timeout_err;
  modport slave (
    input  cmd_pc_ram, cmd_ram_pc, cmd_process, cmd_idle, rx_done, proc_done, tx_done,
    output rx_start, proc_start, tx_start, rx_en, proc_en, tx_en, abort, cmd_reject,
           mode, busy, img_loaded, img_processed, timeout_err
  );
  modport master (
    output cmd_pc_ram, cmd_ram_pc, cmd_process, cmd_idle, rx_done, proc_done, tx_done,
    input  rx_start, proc_start, tx_start, rx_en, proc_en, tx_en, abort, cmd_reject,
           mode, busy, img_loaded, img_processed, timeout_err
  );
endinterface

// File: rtl/mode_sequencer_op_watchdog.sv
// op_watchdog: saturating per-state cycle counter that flags when the allowed time is used up
module op_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
  parameter int          TO_W           = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam logic [TO_W-1:0] LIM = TO_W'(TIMEOUT_CYCLES);
  logic [TO_W-1:0] cnt;
  // count active cycles, stopping at the limit; a zero limit keeps the counter parked at 0
  always_ff @(posedge clk) begin
    if (rst || clr || TIMEOUT_CYCLES == 0) cnt <= '0;
    else if (en && cnt != LIM) cnt <= cnt + TO_W'(1);
  end
  assign expired = TIMEOUT_CYCLES != 0 && cnt == LIM;
endmodule

// File: rtl/mode_sequencer.sv
// mode_sequencer: one-at-a-time controller for the UART receive path, processing core and UART transmit path
module mode_sequencer
  import mode_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
  parameter int          TO_W           = 32
) (
  input logic clk,
  input logic rst,
  mode_sequencer_if.slave b
);
  state_t st, nx;
  out_t o_d, o_q;
  logic act, own, ops, expired;
  assign act = is_busy(st);
  assign own = (st == S_RX && b.rx_done) || (st == S_PROC && b.proc_done) || (st == S_TX && b.tx_done);
  assign ops = b.cmd_pc_ram || b.cmd_process || b.cmd_ram_pc;
  op_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_W(TO_W)) u_wd (
    .clk(clk), .rst(rst), .clr(nx != st), .en(act), .expired(expired)
  );
  // state register; every output is registered alongside it
  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= S_IDLE;
      o_q <= '0;
    end else begin
      st  <= nx;
      o_q <= o_d;
    end
  end
  // next state: IDLE priority idle > pc_ram > process > ram_pc; in active states done beats abort beats timeout
  always_comb begin
    nx = st;
    if (st == S_IDLE)
      nx = b.cmd_idle ? S_IDLE :
           b.cmd_pc_ram ? S_RX :
           b.cmd_process ? (o_q.img_loaded ? S_PROC : S_IDLE) :
           (b.cmd_ram_pc && o_q.img_loaded) ? S_TX : S_IDLE;
    else if (st == S_ERR)
      nx = b.cmd_idle ? S_IDLE : S_ERR;
    else
      nx = (own || b.cmd_idle) ? S_IDLE : expired ? S_ERR : st;
  end
  // next output values, derived from the transition being taken
  always_comb begin
    o_d = '0;
    o_d.rx_start      = st == S_IDLE && nx == S_RX;
    o_d.proc_start    = st == S_IDLE && nx == S_PROC;
    o_d.tx_start      = st == S_IDLE && nx == S_TX;
    o_d.rx_en         = nx == S_RX;
    o_d.proc_en       = nx == S_PROC;
    o_d.tx_en         = nx == S_TX;
    o_d.abort         = act && !own && (b.cmd_idle || expired);
    o_d.cmd_reject    = st == S_IDLE ? !b.cmd_idle && !b.cmd_pc_ram && !o_q.img_loaded && (b.cmd_process || b.cmd_ram_pc) :
                        st == S_ERR  ? !b.cmd_idle && ops : ops;
    o_d.mode          = nx;
    o_d.busy          = is_busy(nx);
    o_d.img_loaded    = (nx == S_ERR || nx == S_RX) ? 1'b0 : (st == S_RX && b.rx_done) || o_q.img_loaded;
    o_d.img_processed = (nx == S_ERR || nx == S_RX || (st == S_PROC && o_d.abort)) ? 1'b0 :
                        (st == S_PROC && b.proc_done) || o_q.img_processed;
    o_d.timeout_err   = nx == S_ERR;
  end
  assign b.rx_start      = o_q.rx_start;
  assign b.proc_start    = o_q.proc_start;
  assign b.tx_start      = o_q.tx_start;
  assign b.rx_en         = o_q.rx_en;
  assign b.proc_en       = o_q.proc_en;
  assign b.tx_en         = o_q.tx_en;
  assign b.abort         = o_q.abort;
  assign b.cmd_reject    = o_q.cmd_reject;
  assign b.mode          = o_q.mode;
  assign b.busy          = o_q.busy;
  assign b.img_loaded    = o_q.img_loaded;
  assign b.img_processed = o_q.img_processed;
  assign b.timeout_err   = o_q.timeout_err;
endmodule

// File: tb/tb_mode_sequencer.sv
// tb_mode_sequencer: directed table, corner sequences and randomized run against a rule-level model
module tb_mode_sequencer;
  localparam int TO = 20;
  logic clk, rst;
  int checks = 0, failures = 0;
  int m_st, m_age;
  bit m_ld, m_pr;
  mode_sequencer_if b();
  mode_sequencer #(.TIMEOUT_CYCLES(TO), .TO_W(8)) dut (.clk(clk), .rst(rst), .b(b));
  wire [14:0] obs = {b.rx_start, b.proc_start, b.tx_start, b.rx_en, b.proc_en, b.tx_en, b.abort,
                     b.cmd_reject, b.mode, b.busy, b.img_loaded, b.img_processed, b.timeout_err};
  typedef struct {
    logic [3:0] c;
    logic [2:0] d;
    int         md;
    bit         ab, rj, ld, pr;
  } vec_t;
  vec_t tbl[$];
  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog_time got=running want=finished");
    $fatal(1);
  end
  function automatic logic [14:0] pack(int ps, int ns, bit ab, bit rj, bit ld, bit pr);
    return {(ps == 0 && ns == 1), (ps == 0 && ns == 2), (ps == 0 && ns == 3), (ns == 1), (ns == 2), (ns == 3),
            ab, rj, 3'(ns), (ns >= 1 && ns <= 3), ld, pr, (ns == 4)};
  endfunction
  task automatic step(input logic [3:0] c, input logic [2:0] d);
    {b.cmd_idle, b.cmd_pc_ram, b.cmd_process, b.cmd_ram_pc} = c;
    {b.rx_done, b.proc_done, b.tx_done} = d;
    @(posedge clk);
    #1;
    {b.cmd_idle, b.cmd_pc_ram, b.cmd_process, b.cmd_ram_pc} = 4'b0;
    {b.rx_done, b.proc_done, b.tx_done} = 3'b0;
  endtask
  task automatic chk(input string nm, input logic [14:0] e);
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL %s got=%b want=%b", nm, obs, e);
    end
  endtask
  task automatic do_reset();
    rst = 1;
    step(4'b0, 3'b0);
    rst = 0;
    chk("reset", 15'b0);
    m_st = 0; m_age = 0; m_ld = 0; m_pr = 0;
  endtask
  task automatic model(input logic [3:0] c, input logic [2:0] d, output logic [14:0] e);
    bit ci, cl, cp, cr, act, own, ops, ab, rj;
    int ns;
    {ci, cl, cp, cr} = c;
    act = m_st >= 1 && m_st <= 3;
    own = (m_st == 1 && d[2]) || (m_st == 2 && d[1]) || (m_st == 3 && d[0]);
    ops = cl || cp || cr;
    ab = 0; rj = 0; ns = m_st;
    if (m_st == 0) begin
      if (!ci) begin
        if (cl) begin ns = 1; m_ld = 0; m_pr = 0; end
        else if (cp || cr) begin
          if (!m_ld) rj = 1;
          else ns = cp ? 2 : 3;
        end
      end
    end else if (m_st == 4) begin
      rj = ops && !ci;
      if (ci) ns = 0;
    end else begin
      rj = ops;
      if (own) begin
        ns = 0;
        if (m_st == 1) m_ld = 1;
        if (m_st == 2) m_pr = 1;
      end else if (ci) begin
        ns = 0; ab = 1;
        if (m_st == 2) m_pr = 0;
      end else if (m_age >= TO) begin
        ns = 4; ab = 1; m_ld = 0; m_pr = 0;
      end
    end
    e = pack(m_st, ns, ab, rj, m_ld, m_pr);
    if (ns != m_st) m_age = 0;
    else if (act && m_age < TO) m_age++;
    m_st = ns;
  endtask
  initial begin
    int prev;
    logic [14:0] e;
    logic [3:0] c;
    logic [2:0] d;
    rst = 0;
    {b.cmd_idle, b.cmd_pc_ram, b.cmd_process, b.cmd_ram_pc} = 4'b0;
    {b.rx_done, b.proc_done, b.tx_done} = 3'b0;
    tbl.push_back('{4'b0010, 3'b000, 0, 0, 1, 0, 0});
    tbl.push_back('{4'b0000, 3'b000, 0, 0, 0, 0, 0});
    tbl.push_back('{4'b0100, 3'b000, 1, 0, 0, 0, 0});
    tbl.push_back('{4'b0000, 3'b000, 1, 0, 0, 0, 0});
    tbl.push_back('{4'b0000, 3'b010, 1, 0, 0, 0, 0});
    tbl.push_back('{4'b0000, 3'b100, 0, 0, 0, 1, 0});
    tbl.push_back('{4'b0010, 3'b000, 2, 0, 0, 1, 0});
    tbl.push_back('{4'b0100, 3'b000, 2, 0, 1, 1, 0});
    tbl.push_back('{4'b0000, 3'b010, 0, 0, 0, 1, 1});
    tbl.push_back('{4'b0001, 3'b000, 3, 0, 0, 1, 1});
    tbl.push_back('{4'b0000, 3'b001, 0, 0, 0, 1, 1});
    tbl.push_back('{4'b0010, 3'b000, 2, 0, 0, 1, 1});
    tbl.push_back('{4'b1000, 3'b000, 0, 1, 0, 1, 0});
    tbl.push_back('{4'b0010, 3'b000, 2, 0, 0, 1, 0});
    tbl.push_back('{4'b1000, 3'b010, 0, 0, 0, 1, 1});
    tbl.push_back('{4'b1111, 3'b000, 0, 0, 0, 1, 1});
    tbl.push_back('{4'b0111, 3'b000, 1, 0, 0, 0, 0});
    tbl.push_back('{4'b0000, 3'b100, 0, 0, 0, 1, 0});
    tbl.push_back('{4'b1000, 3'b000, 0, 0, 0, 1, 0});
    tbl.push_back('{4'b0001, 3'b000, 3, 0, 0, 1, 0});
    tbl.push_back('{4'b0000, 3'b100, 3, 0, 0, 1, 0});
    tbl.push_back('{4'b1000, 3'b000, 0, 1, 0, 1, 0});
    do_reset();
    prev = 0;
    foreach (tbl[i]) begin
      step(tbl[i].c, tbl[i].d);
      chk($sformatf("vec%0d", i), pack(prev, tbl[i].md, tbl[i].ab, tbl[i].rj, tbl[i].ld, tbl[i].pr));
      prev = tbl[i].md;
    end
    step(4'b0100, 3'b000);
    chk("to_enter", pack(0, 1, 0, 0, 0, 0));
    for (int k = 1; k <= TO; k++) begin
      step(4'b0, 3'b0);
      chk($sformatf("to_wait%0d", k), pack(1, 1, 0, 0, 0, 0));
    end
    step(4'b0, 3'b0);
    chk("to_err", pack(1, 4, 1, 0, 0, 0));
    step(4'b0, 3'b0);
    chk("err_hold", pack(4, 4, 0, 0, 0, 0));
    step(4'b0100, 3'b0);
    chk("err_reject", pack(4, 4, 0, 1, 0, 0));
    step(4'b1000, 3'b0);
    chk("err_exit", pack(4, 0, 0, 0, 0, 0));
    step(4'b0100, 3'b0);
    chk("race_enter", pack(0, 1, 0, 0, 0, 0));
    for (int k = 0; k < TO; k++) step(4'b0, 3'b0);
    step(4'b0, 3'b100);
    chk("race_done_wins", pack(1, 0, 0, 0, 1, 0));
    step(4'b0001, 3'b0);
    chk("rst_tx_enter", pack(0, 3, 0, 0, 1, 0));
    step(4'b0, 3'b0);
    rst = 1;
    step(4'b0, 3'b0);
    rst = 0;
    chk("rst_mid_tx", 15'b0);
    step(4'b0, 3'b001);
    chk("stray_tx_done", 15'b0);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int dp;
      dp = i < 1500 ? 7 : 40;
      c = {($urandom_range(15) == 0), ($urandom_range(15) == 0), ($urandom_range(15) == 0), ($urandom_range(15) == 0)};
      d = {($urandom_range(dp) == 0), ($urandom_range(dp) == 0), ($urandom_range(dp) == 0)};
      model(c, d, e);
      step(c, d);
      chk($sformatf("rand%0d", i), e);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mode_sequencer.md
Name: mode_sequencer

Overview:
- Top-level operation controller that consumes the four single-cycle debounced command pulses (PC->RAM load, RAM->PC dump, PROCESS, IDLE) from the debouncer stage.
- Sequences the UART receive path, the image-processing core and the UART transmit path, one operation at a time.
- Issues start pulses and enable levels, tracks completion and image-validity flags, enforces a watchdog timeout, and drives a mode/status code for LEDs.

Parameters:
- TIMEOUT_CYCLES, 500_000_000, cycles allowed in any active state before watchdog error; 0 disables the watchdog.
- TO_W, 32, watchdog counter width; must satisfy TIMEOUT_CYCLES < 2^TO_W.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- cmd_pc_ram  input  1  1-cycle pulse: load image PC->RAM
- cmd_ram_pc  input  1  1-cycle pulse: dump RAM->PC
- cmd_process  input  1  1-cycle pulse: run processing
- cmd_idle  input  1  1-cycle pulse: abort/return to idle
- rx_done  input  1  UART-receive path finished, 1-cycle pulse
- proc_done  input  1  processor finished, 1-cycle pulse
- tx_done  input  1  UART-transmit path finished, 1-cycle pulse
- rx_start, proc_start, tx_start  output  1 each  1-cycle start pulses
- rx_en, proc_en, tx_en  output  1 each  level; high for the whole corresponding state
- abort  output  1  1-cycle pulse when an active operation is cancelled
- cmd_reject  output  1  1-cycle pulse when a command is refused
- mode  output  3  current state code
- busy  output  1  high in RX/PROC/TX
- img_loaded  output  1  RAM holds a complete received image
- img_processed  output  1  RAM holds a processed result
- timeout_err  output  1  sticky; high in ERR state

Behaviour:
- Reset: rst sampled high -> state IDLE; every output 0; mode=0; watchdog=0. Reset mid-operation drops all enables on the next edge with no abort pulse.
- States and mode codes: IDLE=0, RX=1, PROC=2, TX=3, ERR=4. All outputs registered.
- Command latency: command pulse in cycle N -> new state, enable and start pulse visible in cycle N+1. The start pulse lasts exactly one cycle.
- IDLE transitions:
  - cmd_pc_ram -> RX; clears img_loaded and img_processed.
  - cmd_process -> PROC if img_loaded, else cmd_reject.
  - cmd_ram_pc -> TX if img_loaded, else cmd_reject.
  - cmd_idle -> no effect.
- Simultaneous commands in IDLE: priority idle > pc_ram > process > ram_pc. The lower-priority commands are dropped silently, with no reject.
- Active states (RX/PROC/TX):
  - Own done pulse -> IDLE next cycle.
  - RX done sets img_loaded. PROC done sets img_processed. TX done changes no flags.
  - Done pulses that do not belong to the current state are ignored.
  - cmd_idle -> IDLE and abort pulse. An aborted RX leaves img_loaded=0; an aborted PROC leaves img_processed=0 and img_loaded unchanged.
  - cmd_pc_ram, cmd_process or cmd_ram_pc while busy -> cmd_reject pulse; state unchanged.
  - Done and cmd_idle in the same cycle: done wins (completion flags set, no abort).
- Watchdog:
  - Clears on every state entry and increments each cycle in RX/PROC/TX.
  - Reaching TIMEOUT_CYCLES -> ERR next cycle: enables low, abort pulse, timeout_err=1, img_loaded and img_processed cleared.
  - Done arriving in the same cycle the count is reached wins.
  - ERR ignores all commands except cmd_idle, which returns to IDLE and clears timeout_err; other commands give cmd_reject.
- The watchdog counter saturates and never wraps. It is held at 0 when TIMEOUT_CYCLES=0.

Decomposition:
- Shared package holds the state encoding constants (IDLE..ERR, 3-bit) so LED/status logic and the bench decode mode identically.
- One sub-module, op_watchdog (counter, clear, enable, expired flag), parameterised by TIMEOUT_CYCLES and TO_W.
- The FSM and flag logic stay in mode_sequencer.

Test Plan:
- Reset then cmd_pc_ram pulse at cycle 10 -> mode=1, rx_en=1 and rx_start=1 at cycle 11, rx_start=0 at cycle 12. Then rx_done at cycle 40 -> mode=0 and img_loaded=1 at cycle 41.
- From reset, cmd_process -> cmd_reject=1 for one cycle, mode stays 0. After a completed load, cmd_process -> mode=2; proc_done -> img_processed=1. Then cmd_ram_pc -> mode=3; tx_done -> mode=0 with both flags still 1.
- In PROC, assert cmd_idle -> abort=1 one cycle, mode=0, img_processed=0, img_loaded=1. Repeat with proc_done in the same cycle as cmd_idle -> no abort, img_processed=1.
- TIMEOUT_CYCLES=20: enter RX and send no done -> mode=4, timeout_err=1, abort pulse, img_loaded=0 at cycle 21 after entry. cmd_pc_ram -> reject. cmd_idle -> mode=0, timeout_err=0.
- In IDLE with img_loaded=1, pulse all four commands together -> no state change. Pulse pc_ram, process and ram_pc together -> mode=1, flags cleared, no reject.
- Assert rst for one cycle during TX -> next cycle all outputs 0, mode=0, no abort pulse. A stray tx_done afterwards is ignored.
